lcg_stim_gen: RTL and testbench

Synthesizable stimulus source for the fuzz harness: a 32-bit linear congruential generator (LCG) that packs successive draws into a wide flat input vector and hands each vector to the design under test over a valid/ready interface. It replaces the behavioural per-cycle stimulus loop, so a run is reproducible from a 32-bit seed on any simulator or on an FPGA. It sits directly upstream of `top.in_flat`.

---
 rtl/lcg_stim_if.sv | 11 +
 rtl/lcg_stim_gen.sv | 172 +++++++++++++++++
 tb/tb_lcg_stim_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcg_stim_if.sv
// Valid/ready stimulus channel carrying one packed OUT_W-bit vector.
interface lcg_stim_if #(
  parameter int unsigned OUT_W = 267
);
  logic [OUT_W-1:0] stim_flat;
  logic             stim_valid;
  logic             stim_ready;

  modport master (output stim_flat, output stim_valid, input  stim_ready);
  modport slave  (input  stim_flat, input  stim_valid, output stim_ready);
endinterface

// File: rtl/lcg_stim_gen.sv
// Seeded 32-bit LCG stimulus source: packs NWORDS draws per vector and
// streams vectors over a valid/ready channel with a shadow + output 2-deep buffer.
module lcg_stim_gen #(
  parameter int unsigned OUT_W = 267
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [31:0]       seed,
  input  logic              start,
  input  logic [31:0]       num_vec,
  input  logic              abort,
  lcg_stim_if.master        stim,
  output logic              busy,
  output logic              done,
  output logic [31:0]       vec_cnt
);

  localparam int unsigned NWORDS  = (OUT_W + 31) / 32;
  localparam int unsigned IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DRAIN
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      lcg_s, lcg_s_nxt;
  logic [OUT_W-1:0] shadow, shadow_nxt;
  logic             shadow_full, shadow_full_nxt;
  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic [31:0]      remaining, remaining_nxt;
  logic [OUT_W-1:0] flat_nxt;
  logic             valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [31:0]      vec_cnt_nxt;

  logic [31:0]      draw_c;
  logic             accept_c;
  logic             can_load_c;
  logic             last_word_c;
  logic [IDX_W+4:0] bit_ofs_c;
  logic [OUT_W-1:0] word_mask_c;
  logic [OUT_W-1:0] merged_c;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      lcg_s           <= '0;
      shadow          <= '0;
      shadow_full     <= 1'b0;
      word_idx        <= '0;
      remaining       <= '0;
      stim.stim_flat  <= '0;
      stim.stim_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      vec_cnt         <= '0;
    end else begin
      state           <= state_nxt;
      lcg_s           <= lcg_s_nxt;
      shadow          <= shadow_nxt;
      shadow_full     <= shadow_full_nxt;
      word_idx        <= word_idx_nxt;
      remaining       <= remaining_nxt;
      stim.stim_flat  <= flat_nxt;
      stim.stim_valid <= valid_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      vec_cnt         <= vec_cnt_nxt;
    end
  end

  // Next-state, draw/pack and handshake logic
  always_comb begin
    state_nxt       = state;
    lcg_s_nxt       = lcg_s;
    shadow_nxt      = shadow;
    shadow_full_nxt = shadow_full;
    word_idx_nxt    = word_idx;
    remaining_nxt   = remaining;
    flat_nxt        = stim.stim_flat;
    valid_nxt       = stim.stim_valid;
    vec_cnt_nxt     = vec_cnt;
    done_nxt        = 1'b0;

    accept_c    = stim.stim_valid & stim.stim_ready;
    can_load_c  = ~stim.stim_valid | stim.stim_ready;
    draw_c      = lcg_s * LCG_MUL + LCG_INC;
    last_word_c = (word_idx == IDX_W'(NWORDS - 1));
    bit_ofs_c   = {word_idx, 5'd0};
    // Last word lands partly above OUT_W; the shift drops those bits.
    word_mask_c = OUT_W'(32'hFFFF_FFFF) << bit_ofs_c;
    merged_c    = (shadow & ~word_mask_c) | (OUT_W'(draw_c) << bit_ofs_c);

    if (abort && (state != S_IDLE)) begin
      valid_nxt       = 1'b0;
      shadow_nxt      = '0;
      shadow_full_nxt = 1'b0;
      word_idx_nxt    = '0;
      done_nxt        = 1'b1;
      state_nxt       = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_load) begin
            lcg_s_nxt = seed;
          end
          if (start) begin
            remaining_nxt   = num_vec;
            vec_cnt_nxt     = '0;
            word_idx_nxt    = '0;
            shadow_full_nxt = 1'b0;
            if (num_vec == 32'd0) begin
              done_nxt = 1'b1;
            end else begin
              state_nxt = S_GEN;
            end
          end
        end

        S_GEN: begin
          if (accept_c) begin
            valid_nxt   = 1'b0;
            vec_cnt_nxt = vec_cnt + 32'd1;
          end
          // A full shadow stalls the LCG until the output can take it.
          if (!shadow_full) begin
            lcg_s_nxt  = draw_c;
            shadow_nxt = merged_c;
            if (last_word_c) begin
              word_idx_nxt    = '0;
              shadow_full_nxt = 1'b1;
            end else begin
              word_idx_nxt = word_idx + IDX_W'(1);
            end
          end
          if ((shadow_full || last_word_c) && can_load_c) begin
            flat_nxt        = shadow_full ? shadow : merged_c;
            valid_nxt       = 1'b1;
            shadow_full_nxt = 1'b0;
            remaining_nxt   = remaining - 32'd1;
            if (remaining == 32'd1) begin
              state_nxt = S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (accept_c) begin
            valid_nxt   = 1'b0;
            vec_cnt_nxt = vec_cnt + 32'd1;
            done_nxt    = 1'b1;
            state_nxt   = S_IDLE;
          end
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed bench for lcg_stim_gen: latency, sequence, backpressure, abort and reset.
module tb_lcg_stim_gen;

  localparam int unsigned OUT_W  = 267;
  localparam int unsigned NWORDS = 9;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed;
  logic        start;
  logic [31:0] num_vec;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] vec_cnt;

  int n_chk;
  int n_fail;
  int w;
  logic [31:0]      s_m;
  logic [31:0]      s_hi;
  logic [OUT_W-1:0] exp_v;
  logic [OUT_W-1:0] hold_v;

  lcg_stim_if #(.OUT_W(OUT_W)) stim_bus ();

  lcg_stim_gen #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .num_vec   (num_vec),
    .abort     (abort),
    .stim      (stim_bus.master),
    .busy      (busy),
    .done      (done),
    .vec_cnt   (vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  // Reference vector: NWORDS successive draws, word k at bits [32k+31:32k].
  function automatic logic [OUT_W-1:0] model_vec(input logic [31:0] s_in, output logic [31:0] s_out);
    logic [NWORDS*32-1:0] wide;
    logic [31:0] s;
    s = s_in;
    wide = '0;
    for (int k = 0; k < NWORDS; k++) begin
      s = lcg_step(s);
      wide[k*32 +: 32] = s;
    end
    s_out = s;
    return wide[OUT_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!stim_bus.stim_valid && waited < budget);
    check("valid_seen", OUT_W'(stim_bus.stim_valid), OUT_W'(1'b1));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    start = 1'b0;
    num_vec = '0;
    abort = 1'b0;
    stim_bus.stim_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_flat",  stim_bus.stim_flat, '0);
    check("rst_valid", OUT_W'(stim_bus.stim_valid), '0);
    check("rst_busy",  OUT_W'(busy), '0);
    check("rst_done",  OUT_W'(done), '0);
    check("rst_cnt",   OUT_W'(vec_cnt), '0);
    rst_n = 1'b1;
    tick();

    // Seed 0, single vector: first-word constants and 9-cycle latency
    seed_load = 1'b1; seed = 32'd0; tick(); seed_load = 1'b0;
    num_vec = 32'd1; stim_bus.stim_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check("a_busy_rise", OUT_W'(busy), OUT_W'(1'b1));
    wait_valid(20, w);
    check("a_latency", OUT_W'(w), OUT_W'(9));
    check("a_word0", OUT_W'(stim_bus.stim_flat[31:0]), OUT_W'(32'h0000_3039));
    check("a_word1", OUT_W'(stim_bus.stim_flat[63:32]), OUT_W'(32'hD3DC_167E));
    exp_v = model_vec(32'd0, s_m);
    check("a_vec", stim_bus.stim_flat, exp_v);
    tick();
    check("a_done", OUT_W'(done), OUT_W'(1'b1));
    check("a_cnt", OUT_W'(vec_cnt), OUT_W'(1));
    check("a_valid_drop", OUT_W'(stim_bus.stim_valid), '0);
    check("a_busy_fall", OUT_W'(busy), '0);
    tick();
    check("a_done_once", OUT_W'(done), '0);

    // Seed 817804383, four vectors back to back (seed_load+start together)
    seed_load = 1'b1; seed = 32'd817804383; num_vec = 32'd4; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    s_m = 32'd817804383;
    for (int i = 0; i < 4; i++) begin
      wait_valid(30, w);
      check("b_spacing", OUT_W'(w), OUT_W'(9));
      exp_v = model_vec(s_m, s_m);
      check("b_vec", stim_bus.stim_flat, exp_v);
      check("b_top_bits", OUT_W'(stim_bus.stim_flat[266:256]), OUT_W'(s_m[10:0]));
    end
    tick();
    check("b_done", OUT_W'(done), OUT_W'(1'b1));
    check("b_cnt", OUT_W'(vec_cnt), OUT_W'(4));
    tick();

    // Same run with a 30-cycle stall on vector 2
    seed_load = 1'b1; seed = 32'd817804383; num_vec = 32'd4; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    s_m = 32'd817804383;
    wait_valid(30, w);
    exp_v = model_vec(s_m, s_m);
    check("c_vec1", stim_bus.stim_flat, exp_v);
    wait_valid(30, w);
    exp_v = model_vec(s_m, s_m);
    check("c_vec2", stim_bus.stim_flat, exp_v);
    stim_bus.stim_ready = 1'b0;
    hold_v = exp_v;
    repeat (30) begin
      tick();
      check("c_hold_flat", stim_bus.stim_flat, hold_v);
      check("c_hold_valid", OUT_W'(stim_bus.stim_valid), OUT_W'(1'b1));
    end
    stim_bus.stim_ready = 1'b1;
    tick();
    exp_v = model_vec(s_m, s_m);
    check("c_vec3", stim_bus.stim_flat, exp_v);
    check("c_vec3_valid", OUT_W'(stim_bus.stim_valid), OUT_W'(1'b1));
    check("c_cnt2", OUT_W'(vec_cnt), OUT_W'(2));
    wait_valid(30, w);
    check("c_spacing4", OUT_W'(w), OUT_W'(9));
    exp_v = model_vec(s_m, s_m);
    check("c_vec4", stim_bus.stim_flat, exp_v);
    tick();
    check("c_done", OUT_W'(done), OUT_W'(1'b1));
    check("c_cnt", OUT_W'(vec_cnt), OUT_W'(4));
    tick();

    // num_vec = 0: immediate done, no run
    num_vec = 32'd0; start = 1'b1; tick(); start = 1'b0;
    check("d_done", OUT_W'(done), OUT_W'(1'b1));
    check("d_busy", OUT_W'(busy), '0);
    check("d_valid", OUT_W'(stim_bus.stim_valid), '0);
    tick();
    check("d_done_once", OUT_W'(done), '0);
    check("d_busy2", OUT_W'(busy), '0);
    check("d_valid2", OUT_W'(stim_bus.stim_valid), '0);

    // Abort in GEN; seed_load/start while busy must not disturb the run
    seed_load = 1'b1; seed = 32'd0; num_vec = 32'd2; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    tick(); tick();
    seed_load = 1'b1; seed = 32'hDEAD_BEEF; num_vec = 32'd0; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    check("e_busy_kept", OUT_W'(busy), OUT_W'(1'b1));
    check("e_no_done", OUT_W'(done), '0);
    wait_valid(30, w);
    check("e_latency", OUT_W'(w), OUT_W'(6));
    exp_v = model_vec(32'd0, s_m);
    check("e_vec1", stim_bus.stim_flat, exp_v);
    stim_bus.stim_ready = 1'b0;
    repeat (3) begin
      tick();
      s_m = lcg_step(s_m);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    check("e_valid_drop", OUT_W'(stim_bus.stim_valid), '0);
    check("e_done", OUT_W'(done), OUT_W'(1'b1));
    check("e_busy", OUT_W'(busy), '0);
    check("e_cnt", OUT_W'(vec_cnt), '0);
    tick();
    check("e_done_once", OUT_W'(done), '0);

    // Abort in DRAIN; LCG state carried over from the aborted run
    num_vec = 32'd1; start = 1'b1; tick(); start = 1'b0;
    wait_valid(30, w);
    check("f_latency", OUT_W'(w), OUT_W'(9));
    exp_v = model_vec(s_m, s_hi);
    check("f_vec_cont", stim_bus.stim_flat, exp_v);
    seed_load = 1'b1; seed = 32'd5; num_vec = 32'd7; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    check("f_flat_hold", stim_bus.stim_flat, exp_v);
    check("f_valid_hold", OUT_W'(stim_bus.stim_valid), OUT_W'(1'b1));
    check("f_busy_kept", OUT_W'(busy), OUT_W'(1'b1));
    stim_bus.stim_ready = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
    check("f_valid_drop", OUT_W'(stim_bus.stim_valid), '0);
    check("f_done", OUT_W'(done), OUT_W'(1'b1));
    check("f_busy", OUT_W'(busy), '0);
    check("f_cnt", OUT_W'(vec_cnt), '0);
    tick();
    check("f_done_once", OUT_W'(done), '0);

    // Asynchronous reset mid-run, then a fresh seed-0 run
    seed_load = 1'b1; seed = 32'd0; num_vec = 32'd5; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    repeat (12) tick();
    check("g_cnt_mid", OUT_W'(vec_cnt), OUT_W'(1));
    check("g_busy_mid", OUT_W'(busy), OUT_W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("g_rst_flat",  stim_bus.stim_flat, '0);
    check("g_rst_valid", OUT_W'(stim_bus.stim_valid), '0);
    check("g_rst_busy",  OUT_W'(busy), '0);
    check("g_rst_done",  OUT_W'(done), '0);
    check("g_rst_cnt",   OUT_W'(vec_cnt), '0);
    tick();
    rst_n = 1'b1;
    tick();
    seed_load = 1'b1; seed = 32'd0; num_vec = 32'd1; start = 1'b1;
    tick(); seed_load = 1'b0; start = 1'b0;
    wait_valid(30, w);
    check("g_latency", OUT_W'(w), OUT_W'(9));
    check("g_word0", OUT_W'(stim_bus.stim_flat[31:0]), OUT_W'(32'h0000_3039));
    tick();
    check("g_done", OUT_W'(done), OUT_W'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
